noc_apb_ni: RTL and testbench
=============================

NOC_APB_NI -- requirements
Module: noc_apb_ni

Interface
REQ-001 SHALL have parameter GRID_WIDTH, default 4, mesh side length; coordinate width is 2 bits.
REQ-002 SHALL have parameter ROUTER_ROW, default 0, row of the attached router.
REQ-003 SHALL have parameter ROUTER_COL, default 0, column of the attached router.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 256, read-response timeout (used only with the REQ-027 macro).
REQ-005 Ports SHALL be (clock and reset first):
 i_clk  in  1  clock; all logic on the rising edge.
 i_arst_n  in  1  reset, asynchronous, active-low.
 i_psel  in  1  APB select.
 i_penable  in  1  APB enable.
 i_pwrite  in  1  1 = write.
 i_paddr  in  20  [19:18] dst row, [17:16] dst col, [15:0] remote address.
 i_pwdata  in  32  write data.
 o_pready  out  1  APB ready.
 o_prdata  out  32  read data.
 o_pslverr  out  1  APB error.
 o_pkt  out  PACKET_WIDTH  request packet to router NI input.
 o_pktValid  out  1  request valid.
 i_pktReady  in  1  router accepts request.
 i_pkt  in  PACKET_WIDTH  packet from router NI output.
 i_pktValid  in  1  incoming packet valid.
 o_pktReady  out  1  NI accepts incoming packet.
 o_dropped  out  1  one-cycle pulse: incoming packet discarded.

Function
REQ-006 Packet format (PACKET_WIDTH = 58) SHALL be: [1:0] dstCol, [3:2] dstRow, [5:4] srcCol, [7:6] srcRow, [8] isWrite, [9] isResponse, [25:10] addr, [57:26] data.
REQ-007 Request packets SHALL carry src = {ROUTER_ROW, ROUTER_COL}, isResponse = 0, and data = i_pwdata for writes, 0 for reads.
REQ-008 FSM states SHALL be IDLE, SEND, WAIT_RESP, DONE.
REQ-009 IDLE: when i_psel & i_penable, the NI SHALL register the packet and go to SEND on the next edge.
REQ-010 SEND: o_pktValid = 1 and o_pkt SHALL stay stable until i_pktValid... i.e. until i_pktReady is sampled high.
REQ-011 On the SEND handshake, writes SHALL go to DONE and reads SHALL go to WAIT_RESP.
REQ-012 WAIT_RESP: a packet with i_pktValid, isResponse = 1 and src equal to the latched dst SHALL load o_prdata from its data field and go to DONE.
REQ-013 DONE: o_pready = 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-014 Minimum write latency SHALL be 3 cycles from the access phase to o_pready, with i_pktReady high.
REQ-015 o_pktReady SHALL be constantly 1; packets not matching REQ-012 SHALL be discarded with an o_dropped pulse in the following cycle.
REQ-016 A response arriving in the same cycle as the SEND handshake SHALL be dropped.
REQ-017 A local destination (dst == own coordinates) SHALL send no packet and go straight to DONE with o_pslverr = 1 and o_prdata = 0.
REQ-018 o_pslverr SHALL be 0 except as stated in REQ-017 and REQ-027; it is valid only while o_pready = 1.
REQ-019 o_prdata SHALL hold its value until the next read completes.
REQ-020 A new APB access SHALL be accepted only in IDLE.

Reset
REQ-021 On reset assertion, the FSM SHALL go to IDLE immediately, including mid-transaction; any in-flight request is abandoned.
REQ-022 Reset values SHALL be: o_pready 0, o_prdata 0, o_pslverr 0, o_pkt 0, o_pktValid 0, o_dropped 0, timeout counter 0.
REQ-023 o_pktReady SHALL be 0 while i_arst_n is low.

Configuration
REQ-024 Macro NOC_NI_TIMEOUT_EN SHALL compile the read-timeout logic in or out.
REQ-025 With the macro defined, a counter SHALL clear on entry to WAIT_RESP and increment each cycle there.
REQ-026 Without the macro, WAIT_RESP SHALL wait indefinitely and no counter logic is present.
REQ-027 With the macro, the counter reaching TIMEOUT_CYCLES-1 with no response SHALL give DONE with o_pslverr = 1 and o_prdata = 0; a response in that same cycle SHALL win.

Structure
REQ-028 Package pa_noc SHALL hold PACKET_WIDTH, field offsets and widths, a packed packet struct typedef and the FSM state enum.
REQ-029 No sub-module is required; optionally, packet build and parse helpers SHALL be functions in pa_noc.

Verification
REQ-030 Write: ROUTER 0,0, paddr 0x5_1234, pwdata 0xDEADBEEF, i_pktReady high -> o_pkt dst 1,1, addr 0x1234, isWrite 1; o_pready on the 3rd cycle; pslverr 0.
REQ-031 Backpressure: i_pktReady low for 5 cycles -> o_pkt and o_pktValid stable throughout; o_pready 1 cycle after the handshake plus 1.
REQ-032 Read: paddr 0xF_0010 -> after 4 cycles, inject a response from src 3,3 with data 0xCAFEF00D -> o_prdata 0xCAFEF00D and o_pready for 1 cycle.
REQ-033 Mismatched and non-response packets in WAIT_RESP -> o_dropped pulses and still waiting; a later correct response completes.
REQ-034 Local destination: paddr 0x0_0000 at 0,0 -> no o_pktValid; o_pslverr = 1 with o_pready.
REQ-035 With NOC_NI_TIMEOUT_EN and TIMEOUT_CYCLES 16, no response -> o_pslverr 1 and o_prdata 0 after 16 cycles; a reset asserted in SEND -> o_pktValid 0 immediately.

Source files
------------

// File: rtl/pa_noc.sv
// Shared packet layout, FSM state encoding and packet helpers for the NoC APB NI.
package pa_noc;

   localparam int unsigned COORD_W      = 2;
   localparam int unsigned ADDR_W       = 16;
   localparam int unsigned DATA_W       = 32;
   localparam int unsigned PACKET_WIDTH = 58;

   localparam int unsigned OFF_DST_COL  = 0;
   localparam int unsigned OFF_DST_ROW  = 2;
   localparam int unsigned OFF_SRC_COL  = 4;
   localparam int unsigned OFF_SRC_ROW  = 6;
   localparam int unsigned OFF_IS_WRITE = 8;
   localparam int unsigned OFF_IS_RESP  = 9;
   localparam int unsigned OFF_ADDR     = 10;
   localparam int unsigned OFF_DATA     = 26;

   typedef struct packed {
      logic [DATA_W-1:0]  data;
      logic [ADDR_W-1:0]  addr;
      logic               isResponse;
      logic               isWrite;
      logic [COORD_W-1:0] srcRow;
      logic [COORD_W-1:0] srcCol;
      logic [COORD_W-1:0] dstRow;
      logic [COORD_W-1:0] dstCol;
   } noc_pkt_t;

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      WAIT_RESP,
      DONE
   } ni_state_e;

   function automatic logic [PACKET_WIDTH-1:0] build_req(
      input logic [COORD_W-1:0] dst_row,
      input logic [COORD_W-1:0] dst_col,
      input logic [COORD_W-1:0] src_row,
      input logic [COORD_W-1:0] src_col,
      input logic               is_write,
      input logic [ADDR_W-1:0]  addr,
      input logic [DATA_W-1:0]  data
   );
      logic [PACKET_WIDTH-1:0] v;
      v                              = '0;
      v[OFF_DST_COL +: COORD_W]      = dst_col;
      v[OFF_DST_ROW +: COORD_W]      = dst_row;
      v[OFF_SRC_COL +: COORD_W]      = src_col;
      v[OFF_SRC_ROW +: COORD_W]      = src_row;
      v[OFF_IS_WRITE]                = is_write;
      v[OFF_IS_RESP]                 = 1'b0;
      v[OFF_ADDR +: ADDR_W]          = addr;
      v[OFF_DATA +: DATA_W]          = is_write ? data : '0;
      return v;
   endfunction

   function automatic noc_pkt_t parse_pkt(input logic [PACKET_WIDTH-1:0] v);
      return noc_pkt_t'(v);
   endfunction

endpackage

// File: rtl/noc_apb_ni.sv
// APB-slave to NoC network interface: one outstanding request, read responses matched by source.
// Optional read-response timeout compiled in with `define NOC_NI_TIMEOUT_EN.
module noc_apb_ni
   import pa_noc::*;
#(
   parameter int GRID_WIDTH     = 4,
   parameter int ROUTER_ROW     = 0,
   parameter int ROUTER_COL     = 0,
   parameter int TIMEOUT_CYCLES = 256
)(
   input  logic                    i_clk,
   input  logic                    i_arst_n,
   input  logic                    i_psel,
   input  logic                    i_penable,
   input  logic                    i_pwrite,
   input  logic [19:0]             i_paddr,
   input  logic [31:0]             i_pwdata,
   output logic                    o_pready,
   output logic [31:0]             o_prdata,
   output logic                    o_pslverr,
   output logic [PACKET_WIDTH-1:0] o_pkt,
   output logic                    o_pktValid,
   input  logic                    i_pktReady,
   input  logic [PACKET_WIDTH-1:0] i_pkt,
   input  logic                    i_pktValid,
   output logic                    o_pktReady,
   output logic                    o_dropped
);

   localparam logic [COORD_W-1:0] LP_ROW = 2'(ROUTER_ROW % GRID_WIDTH);
   localparam logic [COORD_W-1:0] LP_COL = 2'(ROUTER_COL % GRID_WIDTH);

   ni_state_e               r_state;
   logic [PACKET_WIDTH-1:0] r_pkt;
   logic                    r_pktValid;
   logic                    r_pready;
   logic                    r_pslverr;
   logic                    r_dropped;
   logic [31:0]             r_prdata;
`ifdef NOC_NI_TIMEOUT_EN
   logic [31:0]             r_tmoCnt;
`endif

   noc_pkt_t         w_in;
   logic             w_access;
   logic             w_local;
   logic             w_match;
   logic [COORD_W-1:0] w_dstRow;
   logic [COORD_W-1:0] w_dstCol;
   logic             w_unused;

   assign w_in     = parse_pkt(i_pkt);
   assign w_access = i_psel & i_penable;
   assign w_local  = (i_paddr[19:18] == LP_ROW) && (i_paddr[17:16] == LP_COL);
   assign w_dstRow = r_pkt[OFF_DST_ROW +: COORD_W];
   assign w_dstCol = r_pkt[OFF_DST_COL +: COORD_W];
   assign w_match  = i_pktValid && w_in.isResponse &&
                     (w_in.srcRow == w_dstRow) && (w_in.srcCol == w_dstCol);
   assign w_unused = ^{w_in.dstRow, w_in.dstCol, w_in.isWrite, w_in.addr};

   // Always ready outside reset; anything not consumed as our response is flagged as dropped.
   assign o_pktReady = i_arst_n;
   assign o_pkt      = r_pkt;
   assign o_pktValid = r_pktValid;
   assign o_pready   = r_pready;
   assign o_pslverr  = r_pslverr;
   assign o_prdata   = r_prdata;
   assign o_dropped  = r_dropped;

   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         r_state    <= IDLE;
         r_pkt      <= '0;
         r_pktValid <= 1'b0;
         r_pready   <= 1'b0;
         r_pslverr  <= 1'b0;
         r_dropped  <= 1'b0;
         r_prdata   <= '0;
`ifdef NOC_NI_TIMEOUT_EN
         r_tmoCnt   <= '0;
`endif
      end else begin
         r_dropped <= i_pktValid && !((r_state == WAIT_RESP) && w_match);
         case (r_state)
            IDLE: begin
               if (w_access) begin
                  if (w_local) begin
                     r_pready  <= 1'b1;
                     r_pslverr <= 1'b1;
                     r_prdata  <= '0;
                     r_state   <= DONE;
                  end else begin
                     r_pkt      <= build_req(i_paddr[19:18], i_paddr[17:16], LP_ROW, LP_COL,
                                             i_pwrite, i_paddr[15:0], i_pwdata);
                     r_pktValid <= 1'b1;
                     r_state    <= SEND;
                  end
               end
            end
            SEND: begin
               if (i_pktReady) begin
                  r_pktValid <= 1'b0;
                  if (r_pkt[OFF_IS_WRITE]) begin
                     r_pready <= 1'b1;
                     r_state  <= DONE;
                  end else begin
`ifdef NOC_NI_TIMEOUT_EN
                     r_tmoCnt <= '0;
`endif
                     r_state  <= WAIT_RESP;
                  end
               end
            end
            WAIT_RESP: begin
               if (w_match) begin
                  r_prdata <= w_in.data;
                  r_pready <= 1'b1;
                  r_state  <= DONE;
               end
`ifdef NOC_NI_TIMEOUT_EN
               else if (r_tmoCnt == 32'(TIMEOUT_CYCLES - 1)) begin
                  r_prdata  <= '0;
                  r_pslverr <= 1'b1;
                  r_pready  <= 1'b1;
                  r_state   <= DONE;
               end else begin
                  r_tmoCnt <= r_tmoCnt + 32'd1;
               end
`endif
            end
            DONE: begin
               r_pready  <= 1'b0;
               r_pslverr <= 1'b0;
               r_state   <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_noc_apb_ni.sv
// Scoreboard bench for noc_apb_ni at router (0,0); timeout cases run when NOC_NI_TIMEOUT_EN is defined.
module tb_noc_apb_ni;

   logic        i_clk = 1'b0;
   logic        i_arst_n = 1'b0;
   logic        i_psel = 1'b0;
   logic        i_penable = 1'b0;
   logic        i_pwrite = 1'b0;
   logic [19:0] i_paddr = '0;
   logic [31:0] i_pwdata = '0;
   logic        o_pready;
   logic [31:0] o_prdata;
   logic        o_pslverr;
   logic [57:0] o_pkt;
   logic        o_pktValid;
   logic        i_pktReady = 1'b0;
   logic [57:0] i_pkt = '0;
   logic        i_pktValid = 1'b0;
   logic        o_pktReady;
   logic        o_dropped;

   always #5 i_clk = ~i_clk;

   noc_apb_ni #(
      .GRID_WIDTH    (4),
      .ROUTER_ROW    (0),
      .ROUTER_COL    (0),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .i_clk     (i_clk),
      .i_arst_n  (i_arst_n),
      .i_psel    (i_psel),
      .i_penable (i_penable),
      .i_pwrite  (i_pwrite),
      .i_paddr   (i_paddr),
      .i_pwdata  (i_pwdata),
      .o_pready  (o_pready),
      .o_prdata  (o_prdata),
      .o_pslverr (o_pslverr),
      .o_pkt     (o_pkt),
      .o_pktValid(o_pktValid),
      .i_pktReady(i_pktReady),
      .i_pkt     (i_pkt),
      .i_pktValid(i_pktValid),
      .o_pktReady(o_pktReady),
      .o_dropped (o_dropped)
   );

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } resp_t;

   resp_t       resp_q[$];
   logic [57:0] pkt_q[$];
   int          n_checks = 0;
   int          n_errors = 0;
   logic [57:0] mon_pkt;
   resp_t       mon_resp;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Bit order written out literally: data, addr, isResponse, isWrite, srcRow, srcCol, dstRow, dstCol.
   function automatic logic [57:0] mkpkt(input logic [1:0] dr, input logic [1:0] dc,
                                         input logic [1:0] sr, input logic [1:0] sc,
                                         input logic w, input logic r,
                                         input logic [15:0] a, input logic [31:0] d);
      return {d, a, r, w, sr, sc, dr, dc};
   endfunction

   task automatic tick;
      @(posedge i_clk);
      #1;
   endtask

   task automatic expect_xfer(input bit has_pkt, input logic [57:0] p,
                              input logic [31:0] rd, input logic err);
      resp_t r;
      if (has_pkt) pkt_q.push_back(p);
      r.rdata = rd;
      r.err   = err;
      resp_q.push_back(r);
   endtask

   task automatic apb(input logic wr, input logic [19:0] a, input logic [31:0] wd, output int lat);
      i_psel = 1'b1; i_penable = 1'b0; i_pwrite = wr; i_paddr = a; i_pwdata = wd;
      tick;
      i_penable = 1'b1;
      lat = 0;
      while (lat < 300) begin
         tick;
         lat++;
         if (o_pready) break;
      end
      if (!o_pready) chk("apb_timeout", o_pready, 1);
      tick;
      i_psel = 1'b0; i_penable = 1'b0;
      chk("pready_width", o_pready, 0);
   endtask

   task automatic inject(input logic [57:0] p, input logic exp_drop);
      i_pkt = p; i_pktValid = 1'b1;
      tick;
      i_pktValid = 1'b0; i_pkt = '0;
      chk("dropped", o_dropped, exp_drop);
   endtask

   always @(negedge i_clk) begin
      if (i_arst_n) begin
         if (o_pktValid && i_pktReady) begin
            if (pkt_q.size() == 0) chk("pkt_unexpected", o_pktValid, 0);
            else begin
               mon_pkt = pkt_q.pop_front();
               chk("pkt", o_pkt, mon_pkt);
            end
         end
         if (o_pready) begin
            if (resp_q.size() == 0) chk("pready_unexpected", o_pready, 0);
            else begin
               mon_resp = resp_q.pop_front();
               chk("prdata", o_prdata, mon_resp.rdata);
               chk("pslverr", o_pslverr, mon_resp.err);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          lat;
      logic [57:0] cap;
      logic [57:0] good;

      #12;
      chk("rst_pready", o_pready, 0);
      chk("rst_prdata", o_prdata, 0);
      chk("rst_pslverr", o_pslverr, 0);
      chk("rst_pkt", o_pkt, 0);
      chk("rst_pktValid", o_pktValid, 0);
      chk("rst_dropped", o_dropped, 0);
      chk("rst_pktReady", o_pktReady, 0);
      @(negedge i_clk);
      i_arst_n = 1'b1;
      tick;
      chk("pktReady_on", o_pktReady, 1);

      // Write with router ready.
      i_pktReady = 1'b1;
      expect_xfer(1, mkpkt(2'd1, 2'd1, 2'd0, 2'd0, 1'b1, 1'b0, 16'h1234, 32'hDEADBEEF), 32'h0, 1'b0);
      apb(1'b1, 20'h5_1234, 32'hDEADBEEF, lat);
      chk("wr_latency", lat, 2);

      // Backpressure for five cycles.
      i_pktReady = 1'b0;
      expect_xfer(1, mkpkt(2'd0, 2'd2, 2'd0, 2'd0, 1'b1, 1'b0, 16'h0040, 32'hA5A55A5A), 32'h0, 1'b0);
      fork
         apb(1'b1, 20'h2_0040, 32'hA5A55A5A, lat);
         begin
            for (int k = 0; k < 10 && !o_pktValid; k++) tick;
            chk("bp_valid_seen", o_pktValid, 1);
            cap = o_pkt;
            for (int k = 0; k < 5; k++) begin
               tick;
               chk("bp_valid_hold", o_pktValid, 1);
               chk("bp_pkt_hold", o_pkt, cap);
            end
            i_pktReady = 1'b1;
         end
      join
      chk("bp_latency", lat, 7);

      // Read answered by (3,3).
      expect_xfer(1, mkpkt(2'd3, 2'd3, 2'd0, 2'd0, 1'b0, 1'b0, 16'h0010, 32'h0), 32'hCAFEF00D, 1'b0);
      fork
         apb(1'b0, 20'hF_0010, 32'h11111111, lat);
         begin
            repeat (5) tick;
            inject(mkpkt(2'd0, 2'd0, 2'd3, 2'd3, 1'b0, 1'b1, 16'h0010, 32'hCAFEF00D), 1'b0);
         end
      join
      chk("rd_latency", lat, 5);

      // Response during handshake and mismatched packets are dropped; later match completes.
      good = mkpkt(2'd0, 2'd0, 2'd1, 2'd2, 1'b0, 1'b1, 16'h0100, 32'h12345678);
      expect_xfer(1, mkpkt(2'd1, 2'd2, 2'd0, 2'd0, 1'b0, 1'b0, 16'h0100, 32'h0), 32'h12345678, 1'b0);
      fork
         apb(1'b0, 20'h6_0100, 32'hFFFFFFFF, lat);
         begin
            repeat (2) tick;
            inject(good, 1'b1);
            inject(mkpkt(2'd0, 2'd0, 2'd2, 2'd1, 1'b0, 1'b1, 16'h0100, 32'h0BAD0001), 1'b1);
            inject(mkpkt(2'd0, 2'd0, 2'd1, 2'd2, 1'b0, 1'b0, 16'h0100, 32'h0BAD0002), 1'b1);
            inject(mkpkt(2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1, 16'h0100, 32'h0BAD0003), 1'b1);
            chk("wait_still", o_pready, 0);
            inject(good, 1'b0);
         end
      join
      chk("mm_latency", lat, 6);

`ifdef NOC_NI_TIMEOUT_EN
      expect_xfer(1, mkpkt(2'd1, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 16'h0000, 32'h0), 32'h0, 1'b1);
      apb(1'b0, 20'h4_0000, 32'h0, lat);
      chk("tmo_latency", lat, 18);

      expect_xfer(1, mkpkt(2'd2, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 16'h0004, 32'h0), 32'h0BADCAFE, 1'b0);
      fork
         apb(1'b0, 20'h8_0004, 32'h0, lat);
         begin
            repeat (18) tick;
            inject(mkpkt(2'd0, 2'd0, 2'd2, 2'd0, 1'b0, 1'b1, 16'h0004, 32'h0BADCAFE), 1'b0);
         end
      join
      chk("tmo_resp_wins_latency", lat, 18);
`endif

      // Local destination.
      expect_xfer(0, '0, 32'h0, 1'b1);
      apb(1'b0, 20'h0_0000, 32'h0, lat);
      chk("local_latency", lat, 1);
      chk("local_no_valid", o_pktValid, 0);

      // Reset while in SEND.
      i_pktReady = 1'b0;
      i_psel = 1'b1; i_penable = 1'b0; i_pwrite = 1'b1; i_paddr = 20'h5_0008; i_pwdata = 32'h600DF00D;
      tick;
      i_penable = 1'b1;
      tick;
      chk("send_valid", o_pktValid, 1);
      #2 i_arst_n = 1'b0;
      #1;
      chk("rst_mid_valid", o_pktValid, 0);
      chk("rst_mid_pktReady", o_pktReady, 0);
      chk("rst_mid_pkt", o_pkt, 0);
      i_psel = 1'b0; i_penable = 1'b0;
      @(negedge i_clk);
      i_arst_n = 1'b1;
      tick;
      chk("post_rst_pready", o_pready, 0);
      chk("post_rst_valid", o_pktValid, 0);

      i_pktReady = 1'b1;
      expect_xfer(1, mkpkt(2'd1, 2'd1, 2'd0, 2'd0, 1'b1, 1'b0, 16'h0008, 32'h600DF00D), 32'h0, 1'b0);
      apb(1'b1, 20'h5_0008, 32'h600DF00D, lat);
      chk("post_rst_wr_latency", lat, 2);

      tick;
      chk("queues_empty", resp_q.size() + pkt_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
